wgt_feeder_33: RTL and testbench

- Weight-side transmitter for the 3x3 weight register files: streams 3x3 kernels from weight SRAM into three row-wise 3-tap weight shift registers.
- Drives their shared 8-bit weight bus and per-row read strobes, then signals that a kernel is loaded.
- Waits for the compute side's acknowledge before loading the next kernel.
- Sits between the weight SRAM and the PE-row weight register files.

---
 rtl/wgt_feed_pkg.sv | 33 +++
 rtl/wgt_addr_gen.sv | 53 +++++
 rtl/wgt_feeder_33.sv | 147 ++++++++++++++
 tb/tb_wgt_feeder_33.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wgt_feed_pkg.sv
// Shared constants, state encoding and helpers for the 3x3 weight feeder.
package wgt_feed_pkg;

  // Taps per kernel row and weights per 3x3 kernel.
  localparam int unsigned KTAPS = 3;
  localparam int unsigned KSIZE = 9;

  // Width of the tap counter (0..KSIZE-1).
  localparam int unsigned TAPW = 4;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DRAIN,
    HOLD,
    FIN
  } feed_state_e;

  // Row strobe for a tap index: taps 0-2 feed row 0, 3-5 row 1, 6-8 row 2.
  function automatic logic [KTAPS-1:0] row_onehot(input logic [TAPW-1:0] tap);
    logic [KTAPS-1:0] oh;
    oh = '0;
    if (tap < TAPW'(KTAPS)) begin
      oh = 3'b001;
    end else if (tap < TAPW'(2 * KTAPS)) begin
      oh = 3'b010;
    end else begin
      oh = 3'b100;
    end
    return oh;
  endfunction

endpackage

// File: rtl/wgt_addr_gen.sv
// Kernel/tap counters and the SRAM address adder. The address is
// base + 9k + tap, kept as a running kernel base so no multiplier is needed;
// all arithmetic wraps modulo 2^AW.
module wgt_addr_gen
  import wgt_feed_pkg::*;
#(
  parameter int unsigned AW = 12
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [AW-1:0]   base,
  input  logic            step,
  input  logic            next_kern,
  output logic [AW-1:0]   addr,
  output logic [TAPW-1:0] tap,
  output logic [7:0]      kern_idx,
  output logic            last_tap
);

  logic [AW-1:0]   kern_base_q;
  logic [TAPW-1:0] tap_q;
  logic [7:0]      kern_q;

  // Counter update: load starts a job, next_kern advances by one kernel,
  // step walks the taps of the current kernel.
  always_ff @(posedge clk) begin
    if (rst) begin
      kern_base_q <= '0;
      tap_q       <= '0;
      kern_q      <= '0;
    end else if (load) begin
      kern_base_q <= base;
      tap_q       <= '0;
      kern_q      <= '0;
    end else if (next_kern) begin
      kern_base_q <= kern_base_q + AW'(KSIZE);
      tap_q       <= '0;
      kern_q      <= kern_q + 8'd1;
    end else if (step) begin
      tap_q <= last_tap ? '0 : tap_q + TAPW'(1);
    end
  end

  // Address and status outputs.
  always_comb begin
    addr     = kern_base_q + AW'(tap_q);
    tap      = tap_q;
    kern_idx = kern_q;
    last_tap = (tap_q == TAPW'(KSIZE - 1));
  end

endmodule

// File: rtl/wgt_feeder_33.sv
// Weight-side transmitter: reads 3x3 kernels from weight SRAM and shifts them
// into three row-wise 3-tap weight register files over a shared bus, then
// holds kern_valid until the compute side acknowledges.
module wgt_feeder_33
  import wgt_feed_pkg::*;
#(
  parameter int unsigned AW = 12,
  parameter int unsigned DW = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [AW-1:0]        base_addr,
  input  logic [7:0]           num_kern,
  output logic                 mem_ren,
  output logic [AW-1:0]        mem_addr,
  input  logic [DW-1:0]        mem_rdata,
  output logic signed [DW-1:0] wgt_out,
  output logic [KTAPS-1:0]     wgt_read_row,
  output logic                 kern_valid,
  input  logic                 kern_ack,
  output logic                 busy,
  output logic                 done
);

  feed_state_e state_q, state_d;

  logic [7:0]       num_kern_q;
  logic             drain_q, drain_d;

  // Address generator controls and status.
  logic             ag_load;
  logic             ag_step;
  logic             ag_next;
  logic [AW-1:0]    ag_addr;
  logic [TAPW-1:0]  ag_tap;
  logic [7:0]       ag_kern;
  logic             ag_last;

  // Read pipeline: stage 1 tracks the issued read, stage 2 drives the bus.
  logic             s1_valid_q;
  logic [KTAPS-1:0] s1_row_q;
  logic [DW-1:0]    wgt_q;
  logic [KTAPS-1:0] row_q;

  wgt_addr_gen #(
    .AW (AW)
  ) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .load      (ag_load),
    .base      (base_addr),
    .step      (ag_step),
    .next_kern (ag_next),
    .addr      (ag_addr),
    .tap       (ag_tap),
    .kern_idx  (ag_kern),
    .last_tap  (ag_last)
  );

  // State, job length and drain counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      num_kern_q <= '0;
      drain_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      if (ag_load) begin
        num_kern_q <= num_kern;
      end
    end
  end

  // Next-state logic and address generator sequencing.
  always_comb begin
    state_d = state_q;
    drain_d = 1'b0;
    ag_load = 1'b0;
    ag_step = 1'b0;
    ag_next = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          ag_load = 1'b1;
          state_d = (num_kern == 8'd0) ? FIN : FETCH;
        end
      end
      FETCH: begin
        ag_step = 1'b1;
        if (ag_last) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Two cycles: lets the last read reach the row register files.
        drain_d = ~drain_q;
        if (drain_q) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (kern_ack) begin
          ag_next = 1'b1;
          state_d = (({1'b0, ag_kern} + 9'd1) < {1'b0, num_kern_q}) ? FETCH : FIN;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Read data pipeline; the strobe is only raised for cycles carrying real data
  // and the bus keeps its last weight otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_row_q   <= '0;
      wgt_q      <= '0;
      row_q      <= '0;
    end else begin
      s1_valid_q <= mem_ren;
      s1_row_q   <= row_onehot(ag_tap);
      row_q      <= s1_valid_q ? s1_row_q : '0;
      if (s1_valid_q) begin
        wgt_q <= mem_rdata;
      end
    end
  end

  // Output decode from state and pipeline registers.
  always_comb begin
    mem_ren      = (state_q == FETCH);
    mem_addr     = mem_ren ? ag_addr : '0;
    wgt_out      = wgt_q;
    wgt_read_row = row_q;
    kern_valid   = (state_q == HOLD);
    busy         = (state_q == FETCH) || (state_q == DRAIN) || (state_q == HOLD);
    done         = (state_q == FIN);
  end

endmodule

// File: tb/tb_wgt_feeder_33.sv
// Scoreboard bench for wgt_feeder_33: stimulus pushes expected reads, strobes
// and kernels; a negedge monitor pops and compares as the DUT presents them.
module tb_wgt_feeder_33;

  localparam int AW = 12;
  localparam int DW = 8;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic [AW-1:0]        base_addr;
  logic [7:0]           num_kern;
  logic                 mem_ren;
  logic [AW-1:0]        mem_addr;
  logic [DW-1:0]        mem_rdata = '0;
  logic signed [DW-1:0] wgt_out;
  logic [2:0]           wgt_read_row;
  logic                 kern_valid;
  logic                 kern_ack;
  logic                 busy;
  logic                 done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  wgt_feeder_33 #(
    .AW (AW),
    .DW (DW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .base_addr    (base_addr),
    .num_kern     (num_kern),
    .mem_ren      (mem_ren),
    .mem_addr     (mem_addr),
    .mem_rdata    (mem_rdata),
    .wgt_out      (wgt_out),
    .wgt_read_row (wgt_read_row),
    .kern_valid   (kern_valid),
    .kern_ack     (kern_ack),
    .busy         (busy),
    .done         (done)
  );

  // Weight SRAM model: data valid the cycle after the read.
  logic [7:0] mem [4096];
  always @(posedge clk) if (mem_ren) mem_rdata <= mem[mem_addr];

  // Row register file model: rb[r][2]=buf2 (oldest) .. rb[r][0]=buf0.
  logic [7:0] rb [3][3] = '{default: '0};
  always @(posedge clk) begin
    for (int r = 0; r < 3; r++) begin
      if (wgt_read_row[r]) begin
        rb[r][2] <= rb[r][1];
        rb[r][1] <= rb[r][0];
        rb[r][0] <= wgt_out;
      end
    end
  end

  // Scoreboard queues.
  logic [AW-1:0] q_addr[$];
  logic [10:0]   q_wgt[$];
  logic [71:0]   q_kern[$];

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Row contents packed as w[r][c] at byte 3r+c.
  function automatic logic [71:0] pack_rows();
    logic [71:0] p;
    p = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) p[(3*r+c)*8 +: 8] = rb[r][2-c];
    return p;
  endfunction

  task automatic expect_kernel(input logic [AW-1:0] base, input int k);
    logic [AW-1:0] a;
    logic [71:0]   kv;
    logic [2:0]    oh;
    kv = '0;
    for (int t = 0; t < 9; t++) begin
      a  = base + AW'(9 * k + t);
      oh = 3'b001 << (t / 3);
      q_addr.push_back(a);
      q_wgt.push_back({oh, mem[a]});
      kv[t*8 +: 8] = mem[a];
    end
    q_kern.push_back(kv);
  endtask

  // Monitor: compares every read, strobe and kernel arrival against the queues.
  initial begin
    logic [AW-1:0] ea;
    logic [10:0]   ew;
    logic [71:0]   ek;
    logic          kv_prev;
    kv_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        kv_prev = 1'b0;
      end else begin
        if (mem_ren) begin
          if (q_addr.size() == 0) fail("unexpected_read");
          else begin
            ea = q_addr.pop_front();
            check("mem_addr", {60'd0, mem_addr}, {60'd0, ea});
          end
        end
        if (wgt_read_row != 3'b000) begin
          if (q_wgt.size() == 0) fail("unexpected_strobe");
          else begin
            ew = q_wgt.pop_front();
            check("wgt_row", {69'd0, wgt_read_row}, {69'd0, ew[10:8]});
            check("wgt_val", {64'd0, wgt_out}, {64'd0, ew[7:0]});
          end
        end
        if (kern_valid && !kv_prev) begin
          if (q_kern.size() == 0) fail("unexpected_kern_valid");
          else begin
            ek = q_kern.pop_front();
            check("kernel_rows", pack_rows(), ek);
          end
        end
        kv_prev = kern_valid;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue start in the current cycle (cycle 0); returns in cycle 1.
  task automatic go(input logic [AW-1:0] b, input logic [7:0] n);
    start     = 1'b1;
    base_addr = b;
    num_kern  = n;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_kv(input int bound, output int n);
    n = -1;
    for (int c = 0; c < bound; c++) begin
      if (kern_valid) begin
        n = c;
        break;
      end
      tick();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_ren, first_str, last_str, nstr, kvc;
    int reads, kvn, run, maxrun, dn, viol, n;
    logic [71:0] snap;
    logic [AW-1:0] a;

    rst = 1'b1; start = 1'b0; base_addr = '0; num_kern = '0; kern_ack = 1'b0;
    for (int i = 0; i < 4096; i++) mem[i] = 8'(i ^ 8'h5A);
    tick(); tick(); tick();
    rst = 1'b0;
    check("reset_outputs", {52'd0, mem_ren, mem_addr, wgt_out, wgt_read_row, kern_valid, busy, done},
          72'd0);

    // Single kernel with cycle-exact timing.
    for (int i = 0; i < 9; i++) mem[12'h010 + i] = 8'(i + 1);
    expect_kernel(12'h010, 0);
    go(12'h010, 8'd1);
    check("busy_c1", {71'd0, busy}, 72'd1);
    first_ren = -1; first_str = -1; last_str = -1; nstr = 0; kvc = -1;
    for (int c = 1; c <= 40; c++) begin
      if (mem_ren && first_ren < 0) first_ren = c;
      if (wgt_read_row != 3'b000) begin
        if (first_str < 0) first_str = c;
        last_str = c;
        nstr++;
      end
      if (kern_valid) begin
        kvc = c;
        break;
      end
      tick();
    end
    check("first_read_cycle", 72'(first_ren), 72'd1);
    check("first_strobe_cycle", 72'(first_str), 72'd3);
    check("last_strobe_cycle", 72'(last_str), 72'd11);
    check("strobe_count", 72'(nstr), 72'd9);
    check("kern_valid_cycle", 72'(kvc), 72'd12);
    check("row0_buf2", {64'd0, rb[0][2]}, 72'd1);
    check("row0_buf0", {64'd0, rb[0][0]}, 72'd3);
    check("row2_buf2", {64'd0, rb[2][2]}, 72'd7);
    check("row2_buf0", {64'd0, rb[2][0]}, 72'd9);
    kern_ack = 1'b1;
    tick();
    kern_ack = 1'b0;
    check("t1_done_after_ack", {69'd0, done, kern_valid, busy}, 72'b100);
    tick();
    check("t1_done_pulse_ends", {71'd0, done}, 72'd0);

    // Back-to-back kernels with ack held high.
    for (int i = 0; i < 27; i++) mem[12'h100 + i] = 8'(i * 13 + 5);
    for (int k = 0; k < 3; k++) expect_kernel(12'h100, k);
    kern_ack = 1'b1;
    go(12'h100, 8'd3);
    reads = 0; kvn = 0; run = 0; maxrun = 0; dn = 0;
    for (int c = 1; c <= 200; c++) begin
      reads += int'(mem_ren);
      if (kern_valid) begin
        kvn++;
        run++;
        if (run > maxrun) maxrun = run;
      end else run = 0;
      if (done) begin
        dn++;
        break;
      end
      tick();
    end
    kern_ack = 1'b0;
    check("b2b_reads", 72'(reads), 72'd27);
    check("b2b_kv_cycles", 72'(kvn), 72'd3);
    check("b2b_kv_max_run", 72'(maxrun), 72'd1);
    check("b2b_done_seen", 72'(dn), 72'd1);
    check("b2b_row1_buf2", {64'd0, rb[1][2]}, {64'd0, mem[12'h100 + 21]});
    tick();
    check("b2b_single_done", {70'd0, done, busy}, 72'd0);

    // Delayed ack, with a start pulse in HOLD that must be ignored.
    for (int i = 0; i < 18; i++) mem[12'h200 + i] = 8'(200 - i * 3);
    expect_kernel(12'h200, 0);
    expect_kernel(12'h200, 1);
    go(12'h200, 8'd2);
    wait_kv(40, n);
    if (n < 0) fail("delay_kv_timeout");
    snap = pack_rows();
    viol = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin
        start = 1'b1; base_addr = 12'h000; num_kern = 8'd5;
      end
      tick();
      start = 1'b0;
      if (mem_ren || wgt_read_row != 3'b000 || !kern_valid) viol++;
    end
    check("hold_quiet_cycles", 72'(viol), 72'd0);
    check("hold_rows_stable", pack_rows(), snap);
    kern_ack = 1'b1;
    tick();
    kern_ack = 1'b0;
    check("ack_next_read", {70'd0, mem_ren, kern_valid}, 72'b10);
    wait_kv(40, n);
    if (n < 0) fail("delay_kv2_timeout");
    kern_ack = 1'b1;
    tick();
    kern_ack = 1'b0;
    check("delay_done", {71'd0, done}, 72'd1);
    tick();
    kern_ack = 1'b1;
    tick();
    kern_ack = 1'b0;
    check("ack_in_idle_ignored", {68'd0, busy, mem_ren, done, kern_valid}, 72'd0);

    // num_kern = 0: done in cycle 1, no reads.
    go(12'h050, 8'd0);
    check("zero_kern_c1", {69'd0, done, mem_ren, busy}, 72'b100);
    tick();
    check("zero_kern_c2", {71'd0, done}, 72'd0);

    // Address wrap from 0xFFC.
    for (int i = 0; i < 9; i++) begin
      a = 12'hFFC + 12'(i);
      mem[a] = 8'(8'h40 + i);
    end
    expect_kernel(12'hFFC, 0);
    go(12'hFFC, 8'd1);
    wait_kv(40, n);
    if (n < 0) fail("wrap_kv_timeout");
    check("wrap_row1_buf2", {64'd0, rb[1][2]}, 72'h43);
    check("wrap_row2_buf0", {64'd0, rb[2][0]}, 72'h48);
    kern_ack = 1'b1;
    tick();
    kern_ack = 1'b0;
    check("wrap_done", {71'd0, done}, 72'd1);
    tick();

    // Reset in cycle 5 of FETCH, then a clean restart.
    for (int i = 0; i < 18; i++) mem[12'h300 + i] = 8'(i * 29 + 11);
    expect_kernel(12'h300, 0);
    expect_kernel(12'h300, 1);
    go(12'h300, 8'd2);
    tick(); tick(); tick(); tick();
    check("pre_reset_fetch", {71'd0, mem_ren}, 72'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("post_reset_outputs",
          {52'd0, mem_ren, mem_addr, wgt_out, wgt_read_row, kern_valid, busy, done}, 72'd0);
    q_addr.delete();
    q_wgt.delete();
    q_kern.delete();
    expect_kernel(12'h300, 0);
    go(12'h300, 8'd1);
    wait_kv(40, n);
    check("restart_kv_cycle", 72'(n), 72'd11);
    kern_ack = 1'b1;
    tick();
    kern_ack = 1'b0;
    check("restart_done", {71'd0, done}, 72'd1);
    tick(); tick();

    check("addr_queue_drained", 72'(q_addr.size()), 72'd0);
    check("wgt_queue_drained", 72'(q_wgt.size()), 72'd0);
    check("kern_queue_drained", 72'(q_kern.size()), 72'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
